// File: rtl/mem2_stage_nlane.sv
// MEM2 pipeline stage: registers LANES issue slots, waits for dcache data on lane 0, hands the group to WB.
// Optional sub-word load alignment/extension is enabled by defining M2S_LOAD_ALIGN_EN.
module mem2_stage_nlane #(
    parameter  int LANES  = 2,
    parameter  int DATA_W = 32,
    parameter  int PC_W   = 32,
    parameter  int REG_AW = 5,
    parameter  int WEN_W  = 4,
    localparam int BUS_W  = 7 + WEN_W + 1 + REG_AW + DATA_W + PC_W,
    localparam int OUT_W  = BUS_W - 5,
    localparam int FWD_W  = 3 + REG_AW + DATA_W
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    flush,
    input  logic [LANES-1:0]        m1s_valid,
    input  logic [LANES*BUS_W-1:0]  m1s_to_m2s_bus,
    output logic                    m2s_allowin,
    input  logic                    ws_allowin,
    input  logic                    dcache_data_ok,
    input  logic [DATA_W-1:0]       dcache_rdata,
    output logic [LANES-1:0]        m2s_to_ws_valid,
    output logic [LANES*OUT_W-1:0]  m2s_to_ws_bus,
    output logic [LANES*FWD_W-1:0]  m2s_fwd_bus
);

    localparam int RES_LSB   = PC_W;
    localparam int DEST_LSB  = RES_LSB + DATA_W;
    localparam int GRWE_BIT  = DEST_LSB + REG_AW;
    localparam int WEN_LSB   = GRWE_BIT + 1;
    localparam int ALO_LSB   = WEN_LSB + WEN_W;
    localparam int SIZE_LSB  = ALO_LSB + 2;
    localparam int SEXT_BIT  = SIZE_LSB + 2;
    localparam int LOAD_BIT  = SEXT_BIT + 1;
    localparam int FIRST_BIT = LOAD_BIT + 1;

    logic [LANES-1:0]            r_valid;
    logic [LANES-1:0][BUS_W-1:0] r_bus;
    logic                        r_hold_vld;
    logic [DATA_W-1:0]           r_hold_data;
    logic                        r_discard;

    logic              w_is_load0;
    logic              w_data_ok;
    logic              w_wait_ld;
    logic              w_ready_go;
    logic              w_leave;
    logic [DATA_W-1:0] w_ld_raw;
    logic [DATA_W-1:0] w_ld_data;
    logic              w_unused_fmt;

    assign w_is_load0  = r_bus[0][LOAD_BIT];
    // A response owed to a flushed load is swallowed here, so it can neither complete nor be captured.
    assign w_data_ok   = dcache_data_ok & ~r_discard;
    assign w_wait_ld   = r_valid[0] & w_is_load0 & ~r_hold_vld;
    assign w_ready_go  = ~w_wait_ld | w_data_ok;
    assign w_leave     = w_ready_go & ws_allowin;
    assign m2s_allowin = ~|r_valid | w_leave;
    assign w_ld_raw    = r_hold_vld ? r_hold_data : dcache_rdata;

`ifdef M2S_LOAD_ALIGN_EN
    logic [DATA_W-1:0] w_ld_shift;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        w_unused_fmt = 1'b0;
        for (int i = 1; i < LANES; i++) begin
            w_unused_fmt = w_unused_fmt ^ (^r_bus[i][LOAD_BIT:ALO_LSB]);
        end
        w_ld_shift = w_ld_raw >> {r_bus[0][ALO_LSB +: 2], 3'b000};
        case (r_bus[0][SIZE_LSB +: 2])
            2'd0:    w_ld_data = {{(DATA_W-8){r_bus[0][SEXT_BIT] & w_ld_shift[7]}}, w_ld_shift[7:0]};
            2'd1:    w_ld_data = {{(DATA_W-16){r_bus[0][SEXT_BIT] & w_ld_shift[15]}}, w_ld_shift[15:0]};
            default: w_ld_data = w_ld_shift;
        endcase
    end
`else
    always_comb begin
        w_unused_fmt = ^r_bus[0][SEXT_BIT:ALO_LSB];
        for (int i = 1; i < LANES; i++) begin
            w_unused_fmt = w_unused_fmt ^ (^r_bus[i][LOAD_BIT:ALO_LSB]);
        end
        w_ld_data = w_ld_raw;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= '0;
            r_bus   <= '0;
        end else begin
            if (flush) begin
                r_valid <= '0;
            end else if (m2s_allowin) begin
                r_valid <= m1s_valid;
            end
            if (m2s_allowin && |m1s_valid) begin
                r_bus <= m1s_to_m2s_bus;
            end
        end
    end

    // NOTE: hold_data is reset along with its valid bit so the stage comes out of reset fully defined.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hold_vld  <= 1'b0;
            r_hold_data <= '0;
            r_discard   <= 1'b0;
        end else begin
            if (flush || w_leave) begin
                r_hold_vld <= 1'b0;
            end else if (w_wait_ld && w_data_ok && !ws_allowin) begin
                r_hold_vld  <= 1'b1;
                r_hold_data <= dcache_rdata;
            end
            if (r_discard) begin
                if (dcache_data_ok) begin
                    r_discard <= flush & w_wait_ld;
                end
            end else if (flush && w_wait_ld && !dcache_data_ok) begin
                r_discard <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DATA_W-1:0] w_final;
        logic              w_data_ready;

        if (i == 0) begin : g_mem
            assign w_final      = w_is_load0 ? w_ld_data : r_bus[0][RES_LSB +: DATA_W];
            assign w_data_ready = ~(w_is_load0 & ~w_ready_go);
        end else begin : g_alu
            assign w_final      = r_bus[i][RES_LSB +: DATA_W];
            assign w_data_ready = 1'b1;
        end

        assign m2s_to_ws_valid[i] = r_valid[i] & w_ready_go & ~flush;
        // The WB record carries one spare zero bit above 'first'.
        assign m2s_to_ws_bus[i*OUT_W +: OUT_W] = {1'b0, r_bus[i][FIRST_BIT], r_bus[i][WEN_LSB +: WEN_W],
                                                 r_bus[i][GRWE_BIT], r_bus[i][DEST_LSB +: REG_AW],
                                                 w_final, r_bus[i][PC_W-1:0]};
        assign m2s_fwd_bus[i*FWD_W +: FWD_W]   = {r_valid[i], r_bus[i][GRWE_BIT] & r_valid[i], w_data_ready,
                                                 r_bus[i][DEST_LSB +: REG_AW], w_final};
    end

endmodule

// File: tb/tb_mem2_stage_nlane.sv
// Table-driven bench for mem2_stage_nlane at default parameters, plus a hand-written async-reset sequence.
module tb_mem2_stage_nlane;

    localparam int BUS_W = 81;
    localparam int OUT_W = 76;
    localparam int FWD_W = 40;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic                 flush;
    logic [1:0]           m1s_valid;
    logic [2*BUS_W-1:0]   m1s_to_m2s_bus;
    logic                 m2s_allowin;
    logic                 ws_allowin;
    logic                 dcache_data_ok;
    logic [31:0]          dcache_rdata;
    logic [1:0]           m2s_to_ws_valid;
    logic [2*OUT_W-1:0]   m2s_to_ws_bus;
    logic [2*FWD_W-1:0]   m2s_fwd_bus;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem2_stage_nlane dut (
        .clk             (clk),
        .resetn          (resetn),
        .flush           (flush),
        .m1s_valid       (m1s_valid),
        .m1s_to_m2s_bus  (m1s_to_m2s_bus),
        .m2s_allowin     (m2s_allowin),
        .ws_allowin      (ws_allowin),
        .dcache_data_ok  (dcache_data_ok),
        .dcache_rdata    (dcache_rdata),
        .m2s_to_ws_valid (m2s_to_ws_valid),
        .m2s_to_ws_bus   (m2s_to_ws_bus),
        .m2s_fwd_bus     (m2s_fwd_bus)
    );

    typedef struct {
        string       name;
        logic        fl;
        logic [1:0]  m1v;
        logic        ld0, ld1, sext;
        logic [1:0]  sz, alo;
        logic [4:0]  d0, d1;
        logic [31:0] r0, r1;
        logic        ws, dok;
        logic [31:0] rd;
        logic        ea;
        logic [1:0]  etv, efv;
        logic        erdy;
        logic [4:0]  ed0, ed1;
        logic [31:0] er0, er1;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] pc_of(logic [4:0] d);
        return 32'h1C00_0000 + {25'd0, d, 2'b00};
    endfunction

    function automatic logic [BUS_W-1:0] mk_bus(logic first, logic ld, logic sext, logic [1:0] sz,
                                                logic [1:0] alo, logic [4:0] d, logic [31:0] r);
        return {first, ld, sext, sz, alo, 4'hF, 1'b1, d, r, pc_of(d)};
    endfunction

    function automatic logic [OUT_W-1:0] exp_out(logic first, logic [4:0] d, logic [31:0] r);
        return {1'b0, first, 4'hF, 1'b1, d, r, pc_of(d)};
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic fl, input logic [1:0] m1v, input logic ld0, input logic ld1,
                       input logic sext, input logic [1:0] sz, input logic [1:0] alo,
                       input logic [4:0] d0, input logic [31:0] r0, input logic [4:0] d1, input logic [31:0] r1,
                       input logic ws, input logic dok, input logic [31:0] rd,
                       input logic ea, input logic [1:0] etv, input logic [1:0] efv, input logic erdy,
                       input logic [4:0] ed0, input logic [31:0] er0, input logic [4:0] ed1, input logic [31:0] er1);
        vec_t v;
        v.name = nm; v.fl = fl; v.m1v = m1v; v.ld0 = ld0; v.ld1 = ld1; v.sext = sext; v.sz = sz; v.alo = alo;
        v.d0 = d0; v.r0 = r0; v.d1 = d1; v.r1 = r1; v.ws = ws; v.dok = dok; v.rd = rd;
        v.ea = ea; v.etv = etv; v.efv = efv; v.erdy = erdy; v.ed0 = ed0; v.er0 = er0; v.ed1 = ed1; v.er1 = er1;
        vecs.push_back(v);
    endtask

    // New group offered to an empty stage: always accepted, nothing goes to WB this cycle.
    task automatic present(input string nm, input logic [1:0] m1v, input logic ld0, input logic ld1,
                           input logic sext, input logic [1:0] sz, input logic [1:0] alo,
                           input logic [4:0] d0, input logic [31:0] r0, input logic [4:0] d1, input logic [31:0] r1);
        add(nm, 1'b0, m1v, ld0, ld1, sext, sz, alo, d0, r0, d1, r1, 1'b1, 1'b0, 32'h0,
            1'b1, 2'b00, 2'b00, 1'b1, 5'd0, 32'h0, 5'd0, 32'h0);
    endtask

    // Cycle with no new group from MEM1.
    task automatic idle_cyc(input string nm, input logic fl, input logic ws, input logic dok, input logic [31:0] rd,
                            input logic ea, input logic [1:0] etv, input logic [1:0] efv, input logic erdy,
                            input logic [4:0] ed0, input logic [31:0] er0, input logic [4:0] ed1, input logic [31:0] er1);
        add(nm, fl, 2'b00, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 5'd0, 32'h0, 5'd0, 32'h0, ws, dok, rd,
            ea, etv, efv, erdy, ed0, er0, ed1, er1);
    endtask

    task automatic apply_and_check(input vec_t v);
        logic [FWD_W-1:0] fwd;
        @(negedge clk);
        flush          = v.fl;
        m1s_valid      = v.m1v;
        // With no valid lane the bus carries junk that must not be captured.
        m1s_to_m2s_bus = (v.m1v == 2'b00) ? '1 :
                         {mk_bus(1'b0, v.ld1, 1'b0, 2'd2, 2'd0, v.d1, v.r1),
                          mk_bus(1'b1, v.ld0, v.sext, v.sz, v.alo, v.d0, v.r0)};
        ws_allowin     = v.ws;
        dcache_data_ok = v.dok;
        dcache_rdata   = v.rd;
        #1;
        check({v.name, ".allowin"}, 128'(m2s_allowin), 128'(v.ea));
        check({v.name, ".to_ws_valid"}, 128'(m2s_to_ws_valid), 128'(v.etv));
        for (int i = 0; i < 2; i++) begin
            fwd = m2s_fwd_bus[i*FWD_W +: FWD_W];
            check($sformatf("%s.fwd%0d_flags", v.name, i), 128'(fwd[FWD_W-1 -: 3]),
                  128'({v.efv[i], v.efv[i], (i == 0) ? v.erdy : 1'b1}));
            if (v.efv[i])
                check($sformatf("%s.fwd%0d_dest", v.name, i), 128'(fwd[32 +: 5]), 128'((i == 0) ? v.ed0 : v.ed1));
            if (v.etv[i])
                check($sformatf("%s.ws_bus%0d", v.name, i), 128'(m2s_to_ws_bus[i*OUT_W +: OUT_W]),
                      128'((i == 0) ? exp_out(1'b1, v.ed0, v.er0) : exp_out(1'b0, v.ed1, v.er1)));
        end
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; m1s_valid = 2'b00; m1s_to_m2s_bus = '0;
        ws_allowin = 1'b1; dcache_data_ok = 1'b0; dcache_rdata = 32'h0;
        #12;
        check("rst.allowin", 128'(m2s_allowin), 128'(1'b1));
        check("rst.to_ws_valid", 128'(m2s_to_ws_valid), 128'(2'b00));
        check("rst.fwd_flags", 128'({m2s_fwd_bus[79 -: 3], m2s_fwd_bus[39 -: 3]}), 128'(6'b001_001));
        #10 resetn = 1'b1;

        //       name           fl ws dok rdata          ea  etv    efv    rdy  ed0  er0            ed1  er1
        idle_cyc("reset_idle",  0, 1, 0, 32'h0,          1, 2'b00, 2'b00, 1,   0,   32'h0,         0,   32'h0);
        present ("alu_in", 2'b11, 0, 0, 0, 2'd2, 2'd0, 5'd3, 32'h11, 5'd7, 32'h22);
        idle_cyc("alu_out",     0, 1, 0, 32'h0,          1, 2'b11, 2'b11, 1,   3,   32'h11,        7,   32'h22);
        present ("ld_in", 2'b01, 1, 0, 0, 2'd2, 2'd0, 5'd5, 32'h1000, 5'd0, 32'h0);
        idle_cyc("ld_wait1",    0, 1, 0, 32'h0,          0, 2'b00, 2'b01, 0,   5,   32'h0,         0,   32'h0);
        idle_cyc("ld_wait2",    0, 1, 0, 32'h0,          0, 2'b00, 2'b01, 0,   5,   32'h0,         0,   32'h0);
        idle_cyc("ld_wait3",    0, 1, 0, 32'h0,          0, 2'b00, 2'b01, 0,   5,   32'h0,         0,   32'h0);
        idle_cyc("ld_data",     0, 1, 1, 32'hCAFEBABE,   1, 2'b01, 2'b01, 1,   5,   32'hCAFEBABE,  0,   32'h0);
        present ("hold_in", 2'b01, 1, 0, 0, 2'd2, 2'd0, 5'd6, 32'h2000, 5'd0, 32'h0);
        idle_cyc("hold_wait",   0, 1, 0, 32'h0,          0, 2'b00, 2'b01, 0,   6,   32'h0,         0,   32'h0);
        idle_cyc("hold_dok",    0, 0, 1, 32'hCAFEBABE,   0, 2'b01, 2'b01, 1,   6,   32'hCAFEBABE,  0,   32'h0);
        idle_cyc("hold_stall",  0, 0, 0, 32'hDEADBEEF,   0, 2'b01, 2'b01, 1,   6,   32'hCAFEBABE,  0,   32'h0);
        idle_cyc("hold_go",     0, 1, 0, 32'h12345678,   1, 2'b01, 2'b01, 1,   6,   32'hCAFEBABE,  0,   32'h0);
        present ("fl_in", 2'b01, 1, 0, 0, 2'd2, 2'd0, 5'd8, 32'h3000, 5'd0, 32'h0);
        idle_cyc("fl_flush",    1, 1, 0, 32'h0,          0, 2'b00, 2'b01, 0,   8,   32'h0,         0,   32'h0);
        present ("fl_new_alu", 2'b11, 0, 0, 0, 2'd2, 2'd0, 5'd9, 32'h99, 5'd10, 32'hAA);
        idle_cyc("fl_stale",    0, 1, 1, 32'h55555555,   1, 2'b11, 2'b11, 1,   9,   32'h99,        10,  32'hAA);
        present ("post_ld_in", 2'b01, 1, 0, 0, 2'd2, 2'd0, 5'd11, 32'h4000, 5'd0, 32'h0);
        idle_cyc("post_ld_dat", 0, 1, 1, 32'h0BADF00D,   1, 2'b01, 2'b01, 1,   11,  32'h0BADF00D,  0,   32'h0);
        present ("fl2_in", 2'b01, 1, 0, 0, 2'd2, 2'd0, 5'd20, 32'h8000, 5'd0, 32'h0);
        idle_cyc("fl2_flush",   1, 1, 0, 32'h0,          0, 2'b00, 2'b01, 0,   20,  32'h0,         0,   32'h0);
        present ("fl2_new_ld", 2'b01, 1, 0, 0, 2'd2, 2'd0, 5'd21, 32'h8100, 5'd0, 32'h0);
        idle_cyc("fl2_stale",   0, 1, 1, 32'h5A5A5A5A,   0, 2'b00, 2'b01, 0,   21,  32'h0,         0,   32'h0);
        idle_cyc("fl2_real",    0, 1, 1, 32'h2468ACE0,   1, 2'b01, 2'b01, 1,   21,  32'h2468ACE0,  0,   32'h0);
        present ("fd_in", 2'b01, 1, 0, 0, 2'd2, 2'd0, 5'd12, 32'h5000, 5'd0, 32'h0);
        idle_cyc("fd_fl_dok",   1, 1, 1, 32'h66666666,   1, 2'b00, 2'b01, 1,   12,  32'h0,         0,   32'h0);
        present ("fd_ld_in", 2'b01, 1, 0, 0, 2'd2, 2'd0, 5'd13, 32'h5100, 5'd0, 32'h0);
        idle_cyc("fd_ld_dat",   0, 1, 1, 32'h13579BDF,   1, 2'b01, 2'b01, 1,   13,  32'h13579BDF,  0,   32'h0);
        present ("l1_in", 2'b11, 0, 1, 0, 2'd2, 2'd0, 5'd14, 32'h44, 5'd15, 32'h77);
        idle_cyc("l1_ws0",      0, 0, 0, 32'h0,          0, 2'b11, 2'b11, 1,   14,  32'h44,        15,  32'h77);
        idle_cyc("l1_flush",    1, 0, 0, 32'h0,          0, 2'b00, 2'b11, 1,   14,  32'h0,         15,  32'h0);
        idle_cyc("l1_gone",     0, 1, 0, 32'h0,          1, 2'b00, 2'b00, 1,   0,   32'h0,         0,   32'h0);
        present ("sb_in", 2'b01, 1, 0, 1, 2'd0, 2'd3, 5'd16, 32'h6003, 5'd0, 32'h0);
`ifdef M2S_LOAD_ALIGN_EN
        idle_cyc("sb_data",     0, 1, 1, 32'h80FF1234,   1, 2'b01, 2'b01, 1,   16,  32'hFFFFFF80,  0,   32'h0);
`else
        idle_cyc("sb_data",     0, 1, 1, 32'h80FF1234,   1, 2'b01, 2'b01, 1,   16,  32'h80FF1234,  0,   32'h0);
`endif
        present ("hz_in", 2'b01, 1, 0, 0, 2'd1, 2'd2, 5'd17, 32'h6002, 5'd0, 32'h0);
`ifdef M2S_LOAD_ALIGN_EN
        idle_cyc("hz_data",     0, 1, 1, 32'h80FF1234,   1, 2'b01, 2'b01, 1,   17,  32'h000080FF,  0,   32'h0);
`else
        idle_cyc("hz_data",     0, 1, 1, 32'h80FF1234,   1, 2'b01, 2'b01, 1,   17,  32'h80FF1234,  0,   32'h0);
`endif

        foreach (vecs[k]) apply_and_check(vecs[k]);

        // Async reset while a load waits, then a late response after release.
        @(negedge clk);
        flush = 1'b0; m1s_valid = 2'b01; ws_allowin = 1'b1; dcache_data_ok = 1'b0;
        m1s_to_m2s_bus = {mk_bus(1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 5'd0, 32'h0),
                          mk_bus(1'b1, 1'b1, 1'b0, 2'd2, 2'd0, 5'd18, 32'h7000)};
        @(negedge clk);
        m1s_valid = 2'b00; m1s_to_m2s_bus = '1;
        #1;
        check("ar_wait.allowin", 128'(m2s_allowin), 128'(1'b0));
        #2 resetn = 1'b0;
        #1;
        check("ar_rst.allowin", 128'(m2s_allowin), 128'(1'b1));
        check("ar_rst.to_ws_valid", 128'(m2s_to_ws_valid), 128'(2'b00));
        check("ar_rst.fwd_valid", 128'({m2s_fwd_bus[79], m2s_fwd_bus[39]}), 128'(2'b00));
        @(negedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);
        dcache_data_ok = 1'b1; dcache_rdata = 32'hAAAA5555;
        #1;
        check("ar_late.to_ws_valid", 128'(m2s_to_ws_valid), 128'(2'b00));
        check("ar_late.allowin", 128'(m2s_allowin), 128'(1'b1));
        @(negedge clk);
        dcache_data_ok = 1'b0;
        #1;
        check("ar_after.to_ws_valid", 128'(m2s_to_ws_valid), 128'(2'b00));
        check("ar_after.fwd_valid", 128'({m2s_fwd_bus[79], m2s_fwd_bus[39]}), 128'(2'b00));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
